// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared defaults and helpers for scoreboard_regfile.
`default_nettype none

package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_NREGS  = 32;
  localparam int DEFAULT_NRD    = 2;
  localparam int ZERO_REG       = 0;

  // Widest legal configuration: 64 registers, 4 read ports.
  localparam int MAX_ADDR_W = 6;
  localparam int MAX_NRD    = 4;

  // Extract read port k's index from a zero-extended packed index vector.
  function automatic logic [MAX_ADDR_W-1:0] rd_index(
    input logic [MAX_NRD*MAX_ADDR_W-1:0] idx_vec,
    input int unsigned                   k,
    input int unsigned                   addr_w
  );
    logic [MAX_NRD*MAX_ADDR_W-1:0] shifted;
    logic [MAX_ADDR_W-1:0]         mask;
    shifted  = idx_vec >> (k * addr_w);
    mask     = (MAX_ADDR_W'(1) << addr_w) - MAX_ADDR_W'(1);
    rd_index = shifted[MAX_ADDR_W-1:0] & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- per-register pending bits; a same-cycle mark beats the write-back clear.
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = DEFAULT_NREGS,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_i,
  input  logic [ADDR_W-1:0] wr_reg_i,
  input  logic              mark_en_i,
  input  logic [ADDR_W-1:0] mark_reg_i,
  output logic [NREGS-1:0]  pending_o,
  output logic              any_pending_o
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wb_i && (wr_reg_i == ADDR_W'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (mark_en_i && (mark_reg_i == ADDR_W'(i))) begin
        pending_d[i] = 1'b1;
      end
    end
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o     = pending_q;
  assign any_pending_o = |pending_q;

endmodule

`default_nettype wire

// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile -- register file with registered read ports and pending-operand scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data and readiness to the read ports.
`default_nettype none

module scoreboard_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NREGS  = DEFAULT_NREGS,
  parameter int NRD    = DEFAULT_NRD,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  WB,
  input  logic [ADDR_W-1:0]     wr_reg,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  mark_en,
  input  logic [ADDR_W-1:0]     mark_reg,
  input  logic [NRD*ADDR_W-1:0] rd_reg,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_ready,
  output logic                  any_pending
);

  logic [DATA_W-1:0]             mem_q [NREGS];
  logic [NREGS-1:0]              pending;
  logic [MAX_NRD*MAX_ADDR_W-1:0] rd_reg_ext;
  logic [NRD*DATA_W-1:0]         rd_data_d;
  logic [NRD*DATA_W-1:0]         rd_data_q;
  logic [NRD-1:0]                rd_ready_d;
  logic [NRD-1:0]                rd_ready_q;
  logic                          wr_ok;

  assign wr_ok = WB && (wr_reg != ADDR_W'(ZERO_REG));

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_i          (WB),
    .wr_reg_i      (wr_reg),
    .mark_en_i     (mark_en),
    .mark_reg_i    (mark_reg),
    .pending_o     (pending),
    .any_pending_o (any_pending)
  );

  always_comb begin
    rd_reg_ext                 = '0;
    rd_reg_ext[NRD*ADDR_W-1:0] = rd_reg;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              ready;

    assign idx = ADDR_W'(rd_index(rd_reg_ext, k, ADDR_W));

    always_comb begin
      if (idx == ADDR_W'(ZERO_REG)) begin
        data  = '0;
        ready = 1'b1;
      end else begin
        data  = mem_q[idx];
        ready = ~pending[idx];
      end
`ifdef REGFILE_BYPASS_EN
      // A fresh mark on the same register means a newer producer is still in flight.
      if (wr_ok && (wr_reg == idx)) begin
        data  = wr_data;
        ready = !(mark_en && (mark_reg == idx));
      end
`endif
    end

    assign rd_data_d[k*DATA_W +: DATA_W] = data;
    assign rd_ready_d[k]                 = ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_ready_q <= '1;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_ready_q <= rd_ready_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_ready = rd_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_scoreboard_regfile.sv
// tb_scoreboard_regfile -- vector table plus scoreboard queue for scoreboard_regfile (default parameters).
`default_nettype none

module tb_scoreboard_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        wb;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        mark;
    logic [4:0]  mark_reg;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rdy0;
    logic        rdy1;
    logic        anyp;
  } vec_t;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rdy0;
    logic        rdy1;
    logic        anyp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WB;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        mark_en;
  logic [4:0]  mark_reg;
  logic [9:0]  rd_reg;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic        any_pending;

  int tests = 0;
  int fails = 0;
  exp_t sb_q[$];
  vec_t tbl[$];

  scoreboard_regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .WB          (WB),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .mark_en     (mark_en),
    .mark_reg    (mark_reg),
    .rd_reg      (rd_reg),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .any_pending (any_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic wb, input logic [4:0] wr, input logic [31:0] wd,
    input logic mark, input logic [4:0] mr,
    input logic [4:0] a0, input logic [4:0] a1,
    input logic [31:0] d0, input logic [31:0] d1,
    input logic rdy0, input logic rdy1, input logic anyp);
    vec_t v;
    v.wb = wb; v.wr_reg = wr; v.wr_data = wd; v.mark = mark; v.mark_reg = mr;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.anyp = anyp;
    return v;
  endfunction

  function automatic vec_t rd(input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic rdy0, input logic rdy1, input logic anyp);
    return mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a0, a1, d0, d1, rdy0, rdy1, anyp);
  endfunction

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    WB       = v.wb;
    wr_reg   = v.wr_reg;
    wr_data  = v.wr_data;
    mark_en  = v.mark;
    mark_reg = v.mark_reg;
    rd_reg   = {v.a1, v.a0};
    e.d0 = v.d0; e.d1 = v.d1; e.rdy0 = v.rdy0; e.rdy1 = v.rdy1; e.anyp = v.anyp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    WB      = 1'b0;
    mark_en = 1'b0;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty got 0 expected 1 entry", tag);
    end else begin
      got = sb_q.pop_front();
      chk($sformatf("%s.d0", tag), rd_data[31:0], got.d0);
      chk($sformatf("%s.d1", tag), rd_data[63:32], got.d1);
      chk($sformatf("%s.rdy", tag), {30'd0, rd_ready}, {30'd0, got.rdy1, got.rdy0});
      chk($sformatf("%s.anyp", tag), {31'd0, any_pending}, {31'd0, got.anyp});
    end
  endtask

  initial begin
    rst_n = 1'b0; WB = 1'b0; wr_reg = '0; wr_data = '0;
    mark_en = 1'b0; mark_reg = '0; rd_reg = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.rd_data_lo", rd_data[31:0], 32'd0);
    chk("reset.rd_data_hi", rd_data[63:32], 32'd0);
    chk("reset.rd_ready", {30'd0, rd_ready}, 32'd3);
    chk("reset.anyp", {31'd0, any_pending}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      apply(rd(5'(i), 5'(31 - i), 32'd0, 32'd0, 1'b1, 1'b1, 1'b0), $sformatf("sweep%0d", i));
    end

    // wb, wr, wdata, mark, mreg, a0, a1, d0, d1, rdy0, rdy1, anyp
    tbl.push_back(mk(1, 9, 32'd5, 0, 0, 9, 0, BYP ? 32'd5 : 32'd0, 0, 1, 1, 0));
    tbl.push_back(rd(9, 0, 32'd5, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 9, 0, 32'd5, 1, 1, 0));
    tbl.push_back(rd(0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 10, 10, 9, 0, 32'd5, 1, 1, 1));
    tbl.push_back(rd(10, 10, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 10, 32'd3, 0, 0, 10, 9, BYP ? 32'd3 : 32'd0, 32'd5, BYP, 1, 0));
    tbl.push_back(rd(10, 9, 32'd3, 32'd5, 1, 1, 0));
    tbl.push_back(mk(1, 11, 32'd4, 1, 11, 11, 10, BYP ? 32'd4 : 32'd0, 32'd3, !BYP, 1, 1));
    tbl.push_back(rd(11, 11, 32'd4, 32'd4, 0, 0, 1));
    tbl.push_back(mk(1, 12, 32'd7, 0, 0, 12, 11, BYP ? 32'd7 : 32'd0, 32'd4, 1, 0, 1));
    tbl.push_back(rd(12, 12, 32'd7, 32'd7, 1, 1, 1));
    tbl.push_back(mk(1, 11, 32'd9, 1, 0, 11, 12, BYP ? 32'd9 : 32'd4, 32'd7, BYP, 1, 0));
    tbl.push_back(rd(11, 0, 32'd9, 0, 1, 1, 0));
    tbl.push_back(mk(1, 31, 32'hA5A5_A5A5, 0, 0, 31, 30, BYP ? 32'hA5A5_A5A5 : 32'd0, 0, 1, 1, 0));
    tbl.push_back(rd(31, 30, 32'hA5A5_A5A5, 0, 1, 1, 0));
    tbl.push_back(mk(1, 9, 32'h1234, 1, 31, 9, 31, BYP ? 32'h1234 : 32'd5, 32'hA5A5_A5A5, 1, 1, 1));
    tbl.push_back(rd(31, 9, 32'hA5A5_A5A5, 32'h1234, 0, 1, 1));
    tbl.push_back(mk(1, 31, 32'd0, 0, 0, 1, 2, 0, 0, 1, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Build up pending state, then hit it with a mid-cycle asynchronous reset.
    apply(mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 1, 1), "mark5");
    apply(mk(0, 0, 0, 1, 6, 5, 0, 0, 0, 0, 1, 1), "mark6");
    apply(mk(0, 0, 0, 1, 7, 5, 6, 0, 0, 0, 0, 1), "mark7");
    apply(rd(12, 7, 32'd7, 0, 1, 0, 1), "pre_rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst.rd_data_lo", rd_data[31:0], 32'd0);
    chk("async_rst.rd_data_hi", rd_data[63:32], 32'd0);
    chk("async_rst.rd_ready", {30'd0, rd_ready}, 32'd3);
    chk("async_rst.anyp", {31'd0, any_pending}, 32'd0);
    rst_n = 1'b1;
    apply(rd(5, 9, 0, 0, 1, 1, 0), "post_rst0");
    apply(rd(31, 10, 0, 0, 1, 1, 0), "post_rst1");
    apply(rd(7, 12, 0, 0, 1, 1, 0), "post_rst2");
    apply(rd(11, 6, 0, 0, 1, 1, 0), "post_rst3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter DATA_W, default 32: register and data width in bits, minimum 8.
REQ-002 Parameter NREGS, default 32: register count, power of two, 4..64.
REQ-003 Parameter NRD, default 2: number of read ports, 1..4.
REQ-004 Parameter ADDR_W, default $clog2(NREGS): register index width, derived, not overridden.
REQ-005 Port list, one clock, reset asynchronous and active-low:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- WB  in  1  write-back enable.
- wr_reg  in  ADDR_W  write index.
- wr_data  in  DATA_W  write data.
- mark_en  in  1  issue marks a destination as pending.
- mark_reg  in  ADDR_W  index being marked.
- rd_reg  in  NRD*ADDR_W  packed read indices, port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  packed registered read data.
- rd_ready  out  NRD  registered; 1 = operand not pending.
- any_pending  out  1  OR of all pending bits.

Function
REQ-006 Reads SHALL be registered: rd_data[k] and rd_ready[k] SHALL update on the rising edge of clk where rd_reg[k] is sampled; latency is 1 cycle.
REQ-007 Register 0 SHALL read as 0 and always be ready; WB or mark_en targeting index 0 SHALL be ignored.
REQ-008 When WB=1 and wr_reg!=0, the array entry SHALL take wr_data at the rising edge of clk.
REQ-009 mark_en=1 SHALL set pending[mark_reg] at the edge; if it is already set, it SHALL stay set.
REQ-010 WB=1 SHALL clear pending[wr_reg] at the edge.
REQ-011 mark_en and WB to the same nonzero index in the same cycle SHALL leave pending set (the new producer wins), and the data SHALL still be written.
REQ-012 WB to a non-pending register SHALL write data and leave pending clear.
REQ-013 rd_ready[k] SHALL be the inverse of pending[rd_reg[k]] as held before the edge, subject to REQ-017.
REQ-014 any_pending SHALL be combinational from the pending flops, with no extra latency.
REQ-015 Several read ports addressing the same index SHALL return identical data and ready values.

Reset
REQ-016 While rst_n=0: all array entries = 0, all pending = 0, rd_data = 0, rd_ready = all 1, any_pending = 0; the reset is asserted asynchronously and released synchronously to clk by the surrounding system. A reset asserted mid-operation SHALL discard all pending state.

Configuration
REQ-017 Macro REGFILE_BYPASS_EN, when defined:
- A read in the same cycle as a WB (WB=1, nonzero index equal to rd_reg[k]) SHALL return wr_data.
- rd_ready[k] SHALL be 1 for that read unless mark_en targets the same index in that cycle.
REQ-018 When REGFILE_BYPASS_EN is undefined: same-cycle read-during-write SHALL return the old array value, and rd_ready SHALL reflect the pre-edge pending bit.

Structure
REQ-019 Package regfile_pkg SHALL hold the default DATA_W, NREGS and NRD values, the constant ZERO_REG = 0, and a function to unpack port k's index.
REQ-020 Pending-bit logic SHALL live in sub-module regfile_scoreboard (NREGS pending flops, set/clear/priority, any_pending); the data array and read ports stay in the top.

Verification
REQ-021 Reset then read r0..r31 on two ports -> every rd_data=0, rd_ready=1, any_pending=0.
REQ-022 WB r9=5; next cycle read r9 -> rd_data=5 one cycle after the read index is presented; WB r0=0xFFFF_FFFF then read r0 -> 0.
REQ-023 mark r10, read r10 -> rd_ready=0 and any_pending=1; WB r10=3 -> next read rd_ready=1, rd_data=3, any_pending=0.
REQ-024 Same cycle: mark r11 and WB r11=4 -> pending stays set, a following read gives rd_data=4 and rd_ready=0.
REQ-025 Same cycle: WB r12=7 and read r12 (old value 0) -> rd_data=7, rd_ready=1 with REGFILE_BYPASS_EN; rd_data=0 without it.
REQ-026 mark r5, r6, r7, then drop rst_n for 1 ns mid-cycle -> outputs clear immediately, with any_pending=0 and all registers 0.
